alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 4-bit ALU (ops 0–7: add, sub, and, or, not-a, xor, nand, nor) among NREQ requesters. It accepts one request at a time over a valid/ready handshake and registers the operands into the ALU. It captures the combinational ALU result one cycle later and returns it, tagged with the requester index, over a valid/ready response channel. It sits between the client blocks and the ALU instance; it is the only driver of the ALU's op/a/b inputs.

---
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit ALU among NREQ requesters.
// State | meaning: IDLE = no op in flight; EXEC = operands on ALU; RESP = response held for consumer.
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [3*NREQ-1:0] req_op_i,
    input  logic [4*NREQ-1:0] req_a_i,
    input  logic [4*NREQ-1:0] req_b_i,
    output logic [2:0]        alu_op_o,
    output logic [3:0]        alu_a_o,
    output logic [3:0]        alu_b_o,
    input  logic [3:0]        alu_c_i,
    input  logic              alu_carry_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [3:0]        rsp_c_o,
    output logic              rsp_carry_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t         state_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] id_q;
    logic [2:0]     alu_op_q;
    logic [3:0]     alu_a_q;
    logic [3:0]     alu_b_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [3:0]     rsp_c_q;
    logic           rsp_carry_q;

    logic           can_accept;
    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   cand_sum;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] ptr_d;
    logic           grant_fire;
    logic [2:0]     sel_op;
    logic [3:0]     sel_a;
    logic [3:0]     sel_b;

    assign can_accept = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready_i);

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            end
            cand = cand_sum[IDW-1:0];
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_op = req_op_i[3*i +: 3];
                sel_a  = req_a_i[4*i +: 4];
                sel_b  = req_b_i[4*i +: 4];
            end
        end
    end

    assign ptr_d      = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    assign grant_fire = can_accept && grant_vld;

    // Gated by rst_n so no grant is advertised while reset is held.
    assign req_ready_o = (rst_n_i && grant_fire) ? (NREQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_c_q     <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            if (grant_fire) begin
                alu_op_q <= sel_op;
                alu_a_q  <= sel_a;
                alu_b_q  <= sel_b;
                id_q     <= grant_idx;
                ptr_q    <= ptr_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (grant_fire) state_q <= S_EXEC;
                end
                S_EXEC: begin
                    rsp_c_q     <= alu_c_i;
                    rsp_carry_q <= (alu_op_q[2:1] == 2'b00) ? alu_carry_i : 1'b0;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= grant_fire ? S_EXEC : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_op_o    = alu_op_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_c_o     = rsp_c_q;
    assign rsp_carry_o = rsp_carry_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 4-bit ALU in the loop.
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op = '0;
    logic [4*NREQ-1:0] req_a = '0;
    logic [4*NREQ-1:0] req_b = '0;
    logic [2:0]        alu_op;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [3:0]        alu_c;
    logic              alu_carry;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_c;
    logic              rsp_carry;
    logic              busy;
    logic              force_carry = 1'b0;
    logic [4:0]        alu_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_c_i(alu_c), .alu_carry_i(alu_carry),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_c_o(rsp_c), .rsp_carry_o(rsp_carry),
        .busy_o(busy)
    );

    // ALU: carry is the 5th sum bit for add and the borrow for sub.
    always_comb begin
        alu_r = '0;
        case (alu_op)
            3'd0: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: alu_r = {1'b0, alu_a & alu_b};
            3'd3: alu_r = {1'b0, alu_a | alu_b};
            3'd4: alu_r = {1'b0, ~alu_a};
            3'd5: alu_r = {1'b0, alu_a ^ alu_b};
            3'd6: alu_r = {1'b0, ~(alu_a & alu_b)};
            default: alu_r = {1'b0, ~(alu_a | alu_b)};
        endcase
        alu_c     = alu_r[3:0];
        alu_carry = alu_r[4] | force_carry;
    end

    task automatic set_payload(input int idx, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op[3*idx +: 3] = op;
        req_a[4*idx +: 4]  = a;
        req_b[4*idx +: 4]  = b;
    endtask

    // Issues one request alone and returns the response; ok=0 on timeout.
    task automatic do_op(input int idx, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] c, output logic cy, output logic [IDW-1:0] rid, output bit ok);
        int n;
        ok = 1'b0; c = '0; cy = 1'b0; rid = '0;
        @(negedge clk);
        set_payload(idx, op, a, b);
        req_valid = NREQ'(1) << idx;
        rsp_ready = 1'b1;
        n = 0;
        #1;
        while (!req_ready[idx] && n < 10) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready[idx]) begin
            req_valid = '0;
            return;
        end
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk); n++;
        end
        if (!rsp_valid) return;
        c = rsp_c; cy = rsp_carry; rid = rsp_id; ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        #3;
        total++;
        if ({req_ready, rsp_valid, busy, alu_op, alu_a, alu_b, rsp_c, rsp_carry, rsp_id} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b op=%0d a=%0h b=%0h c=%0h cy=%b id=%0d, expected all 0",
                     req_ready, rsp_valid, busy, alu_op, alu_a, alu_b, rsp_c, rsp_carry, rsp_id);
        end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        @(negedge clk);
        set_payload(2, 3'd0, 4'd8, 4'd4);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        total++;
        if ({rsp_valid, busy, req_ready, alu_a, alu_b} !== {1'b0, 1'b1, 4'b0000, 4'd8, 4'd4}) begin
            bad++;
            $display("FAIL single_exec: got v=%b busy=%b rdy=%b a=%0h b=%0h expected v=0 busy=1 rdy=0000 a=8 b=4",
                     rsp_valid, busy, req_ready, alu_a, alu_b);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_id, rsp_c, rsp_carry} !== {1'b1, 2'd2, 4'b1100, 1'b0}) begin
            bad++;
            $display("FAIL single_rsp: got v=%b id=%0d c=%b cy=%b expected v=1 id=2 c=1100 cy=0",
                     rsp_valid, rsp_id, rsp_c, rsp_carry);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL single_idle: got v=%b busy=%b expected 0 0", rsp_valid, busy); end
    endtask

    task automatic test_carry_mask();
        logic [3:0] c; logic cy; logic [IDW-1:0] rid; bit ok;
        do_op(0, 3'd1, 4'd3, 4'd5, c, cy, rid, ok);
        total++;
        if ({ok, rid, c, cy} !== {1'b1, 2'd0, 4'b1110, 1'b1}) begin
            bad++; $display("FAIL sub_carry: got ok=%b id=%0d c=%b cy=%b expected ok=1 id=0 c=1110 cy=1", ok, rid, c, cy);
        end
        force_carry = 1'b1;
        do_op(0, 3'd2, 4'hF, 4'hF, c, cy, rid, ok);
        total++;
        if ({ok, c, cy} !== {1'b1, 4'hF, 1'b0}) begin
            bad++; $display("FAIL and_carry_masked: got ok=%b c=%h cy=%b expected ok=1 c=f cy=0", ok, c, cy);
        end
        do_op(0, 3'd0, 4'd1, 4'd1, c, cy, rid, ok);
        total++;
        if ({ok, c, cy} !== {1'b1, 4'd2, 1'b1}) begin
            bad++; $display("FAIL add_carry_passed: got ok=%b c=%h cy=%b expected ok=1 c=2 cy=1", ok, c, cy);
        end
        force_carry = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_rdy;
        test_reset();
        for (int i = 0; i < NREQ; i++) set_payload(i, 3'd3, 4'(i), 4'd0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_rdy = (k % 2 == 0) ? (4'b0001 << ((k / 2) % 4)) : 4'b0000;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_rdy);
            end
            if (k >= 2 && k % 2 == 0) begin
                total++;
                if ({rsp_valid, rsp_id, rsp_c} !== {1'b1, 2'((k / 2 - 1) % 4), 4'((k / 2 - 1) % 4)}) begin
                    bad++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d c=%0h expected v=1 id=%0d c=%0h",
                                    k, rsp_valid, rsp_id, rsp_c, (k / 2 - 1) % 4, (k / 2 - 1) % 4);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        test_reset();
        set_payload(0, 3'd0, 4'd1, 4'd2);
        set_payload(1, 3'd5, 4'd6, 4'd3);
        set_payload(3, 3'd0, 4'd1, 4'd1);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b1010;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({rsp_valid, rsp_id, rsp_c, rsp_carry, req_ready} !== {1'b1, 2'd0, 4'd3, 1'b0, 4'b0000}) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d c=%0h cy=%b rdy=%b expected v=1 id=0 c=3 cy=0 rdy=0000",
                                k, rsp_valid, rsp_id, rsp_c, rsp_carry, req_ready);
            end
            if (k < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_grant: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        total++;
        if ({rsp_valid, busy, alu_op, alu_a, alu_b} !== {1'b0, 1'b1, 3'd5, 4'd6, 4'd3}) begin
            bad++; $display("FAIL bp_exec1: got v=%b busy=%b op=%0d a=%0h b=%0h expected v=0 busy=1 op=5 a=6 b=3",
                            rsp_valid, busy, alu_op, alu_a, alu_b);
        end
        @(negedge clk);
        #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_c, req_ready} !== {1'b1, 2'd1, 4'd5, 4'b1000}) begin
            bad++; $display("FAIL bp_rsp1: got v=%b id=%0d c=%0h rdy=%b expected v=1 id=1 c=5 rdy=1000",
                            rsp_valid, rsp_id, rsp_c, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_id, rsp_c} !== {1'b1, 2'd3, 4'd2}) begin
            bad++; $display("FAIL bp_rsp3: got v=%b id=%0d c=%0h expected v=1 id=3 c=2", rsp_valid, rsp_id, rsp_c);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        set_payload(2, 3'd0, 4'd8, 4'd4);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_exec: got busy=%b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, busy, alu_op, alu_a, alu_b, rsp_c, rsp_carry, rsp_id} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got rdy=%b v=%b busy=%b op=%0d a=%0h b=%0h c=%0h cy=%b id=%0d expected all 0",
                     req_ready, rsp_valid, busy, alu_op, alu_a, alu_b, rsp_c, rsp_carry, rsp_id);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, busy} !== 2'b00) begin
                bad++; $display("FAIL rst_no_rsp[%0d]: got v=%b busy=%b expected 0 0", k, rsp_valid, busy);
            end
        end
        req_valid = 4'b1101;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_ptr_zero: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_op_sweep();
        logic [3:0] exp_c [8] = '{4'd12, 4'd4, 4'd0, 4'd12, 4'd7, 4'd12, 4'd15, 4'd3};
        logic [3:0] c; logic cy; logic [IDW-1:0] rid; bit ok;
        for (int op = 0; op < 8; op++) begin
            do_op(1, 3'(op), 4'd8, 4'd4, c, cy, rid, ok);
            total++;
            if ({ok, rid, c, cy} !== {1'b1, 2'd1, exp_c[op], 1'b0}) begin
                bad++; $display("FAIL sweep_op%0d: got ok=%b id=%0d c=%0d cy=%b expected ok=1 id=1 c=%0d cy=0",
                                op, ok, rid, c, cy, exp_c[op]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_carry_mask();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_op();
        test_op_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
